// File: rtl/activation_scheduler.sv
// activation_scheduler: walks each element of an input vector through two LUT reads and a shared interpolator.
// Optional ACT_CLAMP_EN: the top segment reuses its base word, so a 16-entry LUT suffices.
module activation_scheduler #(
   parameter int NUM_NEURONS = 4,
   parameter int DATA_W      = 8,
   parameter int FRAC_W      = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [NUM_NEURONS*DATA_W-1:0] in_data,
   output logic [4:0]                    lut_addr,
   input  logic [DATA_W-1:0]             lut_data,
   output logic [DATA_W-1:0]             interp_remaining,
   output logic [DATA_W-1:0]             interp_base,
   output logic [DATA_W-1:0]             interp_next,
   input  logic [DATA_W-1:0]             interp_value,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [NUM_NEURONS*DATA_W-1:0] out_data
);
`ifdef ACT_CLAMP_EN
   localparam bit CLAMP = 1'b1;
`else
   localparam bit CLAMP = 1'b0;
`endif
   localparam int IW = DATA_W - FRAC_W;
   localparam int CW = NUM_NEURONS > 1 ? $clog2(NUM_NEURONS) : 1;
   typedef enum logic [2:0] {IDLE, RD_BASE, RD_NEXT, CALC, WRITE, DONE} state_t;
   state_t state, state_nxt;
   logic [NUM_NEURONS*DATA_W-1:0] vec;
   logic [CW-1:0] i;
   logic [DATA_W-1:0] x, base, next, rem;
   logic [IW-1:0] idx;
   logic [4:0] addr_base, addr_next;
   logic hold, last;
   assign x = vec[DATA_W*32'(i) +: DATA_W];
   // flipping the sign bit of the signed integer part is the same as adding 2^(IW-1)
   assign idx = {~x[DATA_W-1], x[DATA_W-2:FRAC_W]};
   assign hold = CLAMP && (&idx);
   assign last = i == CW'(NUM_NEURONS - 1);
   assign addr_base = 5'(idx);
   assign addr_next = hold ? addr_base : addr_base + 5'd1;
   assign interp_base = base;
   assign interp_next = next;
   assign interp_remaining = rem;
   always_comb begin
      state_nxt = state;
      in_ready = state == IDLE;
      out_valid = state == DONE;
      lut_addr = state == RD_BASE ? addr_base : state == RD_NEXT ? addr_next : 5'd0;
      case (state)
         IDLE:    state_nxt = in_valid ? RD_BASE : IDLE;
         RD_BASE: state_nxt = RD_NEXT;
         RD_NEXT: state_nxt = CALC;
         CALC:    state_nxt = WRITE;
         WRITE:   state_nxt = last ? DONE : RD_BASE;
         DONE:    state_nxt = out_ready ? IDLE : DONE;
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         vec <= '0;
         i <= '0;
         base <= '0;
         next <= '0;
         rem <= '0;
         out_data <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && in_valid) begin
            vec <= in_data;
            i <= '0;
         end
         if (state == RD_NEXT) begin
            base <= lut_data;
            if (hold) next <= lut_data;
         end
         if (state == CALC) begin
            rem <= {{IW{1'b0}}, x[FRAC_W-1:0]};
            if (!hold) next <= lut_data;
         end
         if (state == WRITE) begin
            out_data[DATA_W*32'(i) +: DATA_W] <= interp_value;
            if (!last) i <= i + CW'(1);
         end
      end
   end
endmodule

// File: doc/activation_scheduler.md
ACTIVATION_SCHEDULER -- requirements
Module: activation_scheduler

Interface
REQ-001 SHALL have parameter NUM_NEURONS, default 4: input elements per vector.
REQ-002 SHALL have parameter DATA_W, default 8: signed element width.
REQ-003 SHALL have parameter FRAC_W, default 4: fraction bits, which are also the interpolator shift.
REQ-004 SHALL have the following ports, clock and reset first:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  scheduler can accept a vector.
- in_data  in  NUM_NEURONS*DATA_W  packed signed inputs, element 0 at LSBs.
- lut_addr  out  5  activation LUT read address.
- lut_data  in  DATA_W  LUT word, valid one cycle after lut_addr.
- interp_remaining  out  DATA_W  to shared interpolator.
- interp_base  out  DATA_W  to shared interpolator.
- interp_next  out  DATA_W  to shared interpolator.
- interp_value  in  DATA_W  combinational interpolator result.
- out_valid  out  1  result vector valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  NUM_NEURONS*DATA_W  packed results, same element order as in_data.

Function
REQ-005 SHALL implement the FSM states IDLE, RD_BASE, RD_NEXT, CALC and DONE.
REQ-006 IDLE SHALL drive in_ready=1; all other states SHALL drive in_ready=0.
REQ-007 on in_valid&&in_ready the scheduler SHALL register in_data, clear the element counter i, and go to RD_BASE.
REQ-008 SHALL ignore in_valid in every state except IDLE.
REQ-009 for element x, the base index SHALL be idx = signed x[DATA_W-1:FRAC_W] + 8, range 0..15.
REQ-010 for element x, remaining SHALL be x[FRAC_W-1:0] zero-extended to DATA_W, range 0..15.
REQ-011 RD_BASE SHALL drive lut_addr=idx and then go to RD_NEXT.
REQ-012 RD_NEXT SHALL capture lut_data as base, drive lut_addr=idx+1, and then go to CALC.
REQ-013 CALC SHALL capture lut_data as next.
REQ-014 interp_* SHALL be driven only from registered base, next and remaining.
REQ-015 interp_value SHALL be written to element i of out_data on the cycle after CALC.
REQ-016 CALC SHALL be followed by a write cycle, which SHALL go to RD_BASE with i+1, or to DONE when i==NUM_NEURONS-1.
REQ-017 each element SHALL take 4 cycles; out_valid SHALL rise exactly 4*NUM_NEURONS cycles after the accepting edge.
REQ-018 DONE SHALL hold out_valid=1 with out_data stable while out_ready=0.
REQ-019 on out_valid&&out_ready the FSM SHALL go to IDLE; in_ready SHALL rise on the next cycle, never on the same cycle.
REQ-020 arithmetic overflow in interp_value SHALL be passed through unmodified.
REQ-021 lut_addr SHALL be 0 in IDLE and DONE.

Reset
REQ-022 rst low SHALL immediately force IDLE, i=0, in_ready=1, out_valid=0, out_data=0, lut_addr=0 and all interp_* outputs to 0.
REQ-023 reset mid-vector SHALL discard the partial result; no out_valid SHALL appear for that vector.

Configuration
REQ-024 with macro ACT_CLAMP_EN defined, when idx==15, RD_NEXT SHALL take next=base, CALC SHALL not use lut_data, and lut_addr 16 SHALL never be issued (LUT depth 16).
REQ-025 without ACT_CLAMP_EN, idx==15 SHALL read address 16 (LUT depth 17).
REQ-026 cycle timing SHALL be identical with and without ACT_CLAMP_EN.

Verification
REQ-027 the bench SHALL cover the following directed scenarios, each with LUT lut[a]=4*a and an ideal interpolator model:
- in_data={0x00,0x08,0xF8,0x10}: out_data={32,34,30,36}; out_valid exactly 16 cycles after the accept edge.
- Element 0x7F without ACT_CLAMP_EN: lut_addr 15 then 16, result 63.
- Element 0x7F with ACT_CLAMP_EN: result 60; address 16 never issued.
- out_ready held low 5 cycles in DONE: out_valid and out_data stable; in_ready stays 0; in_valid pulses ignored.
- rst asserted during element 2: outputs reset at once; the next vector {0x08,0x08,0x08,0x08} yields {34,34,34,34}.
- Back-to-back vectors with out_ready=1: the second accept occurs one cycle after the handshake; no data mixing between vectors.
